pwm_peripheral: RTL and testbench
=================================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: CLK_DIV, default 13, clk cycles per PWM counter step; legal range 1..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: en_out_7_0  input  8  output-enable bits for out[7:0]; synchronous to clk.
REQ-005 Port: en_out_15_8  input  8  output-enable bits for out[15:8]; synchronous to clk.
REQ-006 Port: en_pwm_7_0  input  8  PWM-mode bits for out[7:0]; synchronous to clk.
REQ-007 Port: en_pwm_15_8  input  8  PWM-mode bits for out[15:8]; synchronous to clk.
REQ-008 Port: pwm_duty_cycle  input  8  requested duty, in 1/256 units of the PWM period.
REQ-009 Port: out  output  16  registered output pins.
REQ-010 Port: period_start  output  1  one-clk pulse marking the first clk of each PWM period.

Function
REQ-011 Prescaler: counts 0..CLK_DIV-1, wraps to 0; tick = (prescaler == CLK_DIV-1); CLK_DIV=1 gives a tick every clk.
REQ-012 Period counter pwm_cnt: 8 bits, increments on tick only, wraps 255->0; one PWM period = 256*CLK_DIV clk cycles.
REQ-013 Duty shadow: loads pwm_duty_cycle on the tick where pwm_cnt wraps 255->0; ignores pwm_duty_cycle changes at all other times (no mid-period glitch).
REQ-014 PWM level: 1 when duty_shadow == 8'hFF; otherwise (pwm_cnt < duty_shadow); duty 8'h00 gives a constant 0.
REQ-015 Per-bit select, i = 0..15, with en_out = {en_out_15_8, en_out_7_0} and en_pwm likewise: en_out[i]=0 -> 0; en_out[i]=1, en_pwm[i]=0 -> 1; both 1 -> PWM level.
REQ-016 out is registered: an enable change on cycle N is visible on out at cycle N+1.
REQ-017 out PWM bits are computed from the same-cycle pwm_cnt and duty_shadow, so out changes one clk after the counter changes.
REQ-018 All PWM-mode bits share one counter and stay phase-aligned; outputs enabled mid-period join at the current phase.
REQ-019 period_start: registered, high for exactly one clk, in the cycle after the wrap tick (the same cycle pwm_cnt first reads 0 and the new duty_shadow is in effect).
REQ-020 en_pwm[i]=1 with en_out[i]=0 SHALL drive 0; enable takes priority over PWM mode.
REQ-021 The block has no handshake; inputs are sampled every clk, and the block never stalls.

Reset
REQ-022 rst_n low immediately forces out=16'h0000 and period_start=0, independent of clk.
REQ-023 rst_n low clears prescaler, pwm_cnt and duty_shadow to 0.
REQ-024 After rst_n deasserts, counting starts on the first clk edge; the first period uses duty_shadow=0 and runs a full 256*CLK_DIV cycles.
REQ-025 Reset asserted mid-period abandons that period; no partial state survives.

Verification
REQ-026 CLK_DIV=13, all en=1, duty=8'h80, steady state -> each PWM bit high 1664 clks, low 1664 clks; period_start spacing 3328 clks.
REQ-027 Duty 8'h00 then 8'hFF, all PWM-enabled -> out=16'h0000 for a full period, then 16'hFFFF for a full period; changes occur only at period_start.
REQ-028 Duty 0x40->0xC0 written mid-period -> current period keeps 832-clk high time; next period has 2496-clk high time.
REQ-029 en_out=16'hA5A5, en_pwm=16'h0000 -> out=16'hA5A5 one clk later; then en_pwm=16'hFFFF with duty 0 -> out=16'h0000.
REQ-030 Reset pulse during the high phase with duty=8'hFF -> out drops to 0 asynchronously; after release, first period_start occurs 256*CLK_DIV clks later.
REQ-031 CLK_DIV=1, duty=8'h01 -> each PWM bit high exactly 1 clk per 256-clk period.

Source files
------------

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output PWM generator with prescaler and period-aligned duty update
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_out_7_0,
  input  logic [7:0]  en_out_15_8,
  input  logic [7:0]  en_pwm_7_0,
  input  logic [7:0]  en_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] prescaler_q, prescaler_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_out_15_8, en_out_7_0};
  assign en_pwm = {en_pwm_15_8, en_pwm_7_0};

  always_comb begin
    tick           = (prescaler_q == DIV_LAST);
    wrap           = tick && (pwm_cnt_q == 8'hFF);
    prescaler_d    = tick ? 16'd0 : prescaler_q + 16'd1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // Duty is only sampled at the period boundary so a period never glitches.
    duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = wrap;
  end

  always_comb begin
    pwm_level = (duty_shadow_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_shadow_q);
    // Enable dominates; PWM mode only matters for enabled bits.
    out_d     = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed self-checking bench for pwm_peripheral
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out0, out1;
  logic        ps0, ps1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_out_7_0(eo_lo), .en_out_15_8(eo_hi),
    .en_pwm_7_0(ep_lo), .en_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out0), .period_start(ps0)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .rst_n(rst_n),
    .en_out_7_0(eo_lo), .en_out_15_8(eo_hi),
    .en_pwm_7_0(ep_lo), .en_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs to the next period_start of the chosen DUT; writes new_duty part-way through.
  task automatic measure(input bit which, input logic [7:0] new_duty,
                         output int len, output int highs, output int mixed);
    logic [15:0] o;
    logic        p;
    int          limit;
    int          mid;
    len   = 0;
    highs = 0;
    mixed = 0;
    limit = which ? 600 : 7000;
    mid   = which ? 100 : 1000;
    for (int k = 0; k < limit; k++) begin
      step();
      len++;
      if (len == mid) duty = new_duty;
      o = which ? out1 : out0;
      p = which ? ps1 : ps0;
      if (o == 16'hFFFF) highs++;
      else if (o != 16'h0000) mixed++;
      if (p) break;
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  int len, highs, mixed;

  initial begin
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    repeat (3) step();
    check("rst_out", out0, 16'h0000);
    check("rst_ps", ps0, 1'b0);
    check("rst_out_div1", out1, 16'h0000);

    rst_n = 1'b1;
    measure(0, 8'h80, len, highs, mixed);
    check("p1_len", len, 3328);
    check("p1_highs_duty0", highs, 0);

    measure(0, 8'h00, len, highs, mixed);
    check("p2_len", len, 3328);
    check("p2_highs_80", highs, 1664);
    check("p2_phase", mixed, 0);

    measure(0, 8'hFF, len, highs, mixed);
    check("p3_highs_00", highs, 0);

    measure(0, 8'h40, len, highs, mixed);
    check("p4_highs_ff", highs, 3328);
    check("p4_phase", mixed, 0);

    measure(0, 8'hC0, len, highs, mixed);
    check("p5_highs_40_midwrite", highs, 832);

    measure(0, 8'h80, len, highs, mixed);
    check("p6_highs_c0", highs, 2496);

    measure(0, 8'h00, len, highs, mixed);
    check("p7_highs_80", highs, 1664);

    set_en(16'hA5A5, 16'h0000);
    step();
    check("en_static", out0, 16'hA5A5);
    check("en_static_div1", out1, 16'hA5A5);
    set_en(16'hA5A5, 16'hFFFF);
    step();
    check("pwm_duty0", out0, 16'h0000);

    measure(0, 8'hFF, len, highs, mixed);
    check("p8_highs_duty0", highs, 0);
    step();
    check("en_priority", out0, 16'hA5A5);
    set_en(16'hFFFF, 16'hFFFF);
    step();
    check("join_phase", out0, 16'hFFFF);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out0, 16'h0000);
    check("async_rst_ps", ps0, 1'b0);
    duty = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, 8'h01, len, highs, mixed);
    check("post_rst_len", len, 3328);
    check("post_rst_highs", highs, 0);

    measure(1, 8'h01, len, highs, mixed);
    measure(1, 8'h01, len, highs, mixed);
    check("div1_len", len, 256);
    check("div1_highs_01", highs, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
